// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage floating-point multiplier; define FP_MUL_STAT_CNT_EN to build the err/ovf event counters
module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  input  logic [1:0]              round_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    error,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact,
  output logic [15:0]             err_count,
  output logic [15:0]             ovf_count
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;        // mantissa incl. hidden bit
  localparam int PW = 2 * M;             // full product width
  localparam int XW = EXP_W + 2;         // signed working exponent width

  localparam logic signed [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  localparam logic [1:0] RM_UP  = 2'b00;
  localparam logic [1:0] RM_DN  = 2'b01;
  localparam logic [1:0] RM_RNE = 2'b10;

  localparam logic [EXP_W-1:0]  EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [FRAC_W-1:0] FRAC_QNAN = {1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    CLS_NUM  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // Whole pipeline moves together; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- Stage 1: decode + mantissa multiply ----------------
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2:FRAC_W];
  assign eb = b[W-2:FRAC_W];
  assign fa = a[FRAC_W-1:0];
  assign fb = b[FRAC_W-1:0];

  // Exponent-zero operands are flushed to zero regardless of fraction.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);

  cls_t                  s1_cls_d;
  logic                  s1_sign_d;
  logic signed [XW-1:0]  s1_exp_d;
  logic [PW-1:0]         s1_prod_d;

  // Classify the operand pair; NaN outranks infinity outranks zero.
  always_comb begin
    s1_cls_d = CLS_NUM;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      s1_cls_d = CLS_NAN;
    end else if (a_inf || b_inf) begin
      s1_cls_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      s1_cls_d = CLS_ZERO;
    end
  end

  assign s1_sign_d = sa ^ sb;
  assign s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign s1_prod_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

  logic                  v1_q;
  cls_t                  s1_cls_q;
  logic                  s1_sign_q;
  logic signed [XW-1:0]  s1_exp_q;
  logic [PW-1:0]         s1_prod_q;
  logic [1:0]            s1_rm_q;

  // Stage 1 register: capture decoded operands and raw product.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q      <= 1'b0;
      s1_cls_q  <= CLS_NUM;
      s1_sign_q <= 1'b0;
      s1_exp_q  <= '0;
      s1_prod_q <= '0;
      s1_rm_q   <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      s1_cls_q  <= s1_cls_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_prod_q <= s1_prod_d;
      s1_rm_q   <= round_mode;
    end
  end

  // ---------------- Stage 2: normalise + round ----------------
  logic                  s2_top;
  logic [PW-1:0]         s2_norm;
  logic [M-1:0]          s2_mant;
  logic                  s2_guard, s2_rnd, s2_stk, s2_inc, s2_carry;
  logic [M:0]            s2_mant_r;
  logic                  s2_inx_d;
  logic [FRAC_W-1:0]     s2_frac_d;
  logic signed [XW-1:0]  s2_exp_d;

  // Product is in [1,4); shift so the leading one sits at the top, then round.
  always_comb begin
    s2_top   = s1_prod_q[PW-1];
    s2_norm  = s2_top ? s1_prod_q : {s1_prod_q[PW-2:0], 1'b0};
    s2_mant  = s2_norm[PW-1:M];
    s2_guard = s2_norm[M-1];
    s2_rnd   = s2_norm[M-2];
    s2_stk   = |s2_norm[M-3:0];
    s2_inx_d = s2_guard | s2_rnd | s2_stk;
    case (s1_rm_q)
      RM_UP:   s2_inc = s2_inx_d & ~s1_sign_q;
      RM_DN:   s2_inc = s2_inx_d & s1_sign_q;
      RM_RNE:  s2_inc = s2_guard & (s2_rnd | s2_stk | s2_mant[0]);
      default: s2_inc = 1'b0;
    endcase
    s2_mant_r = {1'b0, s2_mant} + {{M{1'b0}}, s2_inc};
    s2_carry  = s2_mant_r[M];
    s2_frac_d = s2_carry ? s2_mant_r[M-1:1] : s2_mant_r[M-2:0];
    s2_exp_d  = s1_exp_q + XW'(s2_top) + XW'(s2_carry);
  end

  logic                  v2_q;
  cls_t                  s2_cls_q;
  logic                  s2_sign_q;
  logic signed [XW-1:0]  s2_exp_q;
  logic [FRAC_W-1:0]     s2_frac_q;
  logic                  s2_inx_q;
  logic [1:0]            s2_rm_q;

  // Stage 2 register: rounded fraction and final unbounded exponent.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q      <= 1'b0;
      s2_cls_q  <= CLS_NUM;
      s2_sign_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_frac_q <= '0;
      s2_inx_q  <= 1'b0;
      s2_rm_q   <= '0;
    end else if (adv) begin
      v2_q      <= v1_q;
      s2_cls_q  <= s1_cls_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s2_exp_d;
      s2_frac_q <= s2_frac_d;
      s2_inx_q  <= s2_inx_d;
      s2_rm_q   <= s1_rm_q;
    end
  end

  // ---------------- Stage 3: pack + flags ----------------
  logic [W-1:0] res_d;
  logic         err_d, ovf_d, unf_d, inx_d;
  logic         to_inf;

  // Overflow saturates to infinity only when rounding moves away from zero.
  assign to_inf = (s2_rm_q == RM_RNE) ||
                  ((s2_rm_q == RM_UP) && !s2_sign_q) ||
                  ((s2_rm_q == RM_DN) && s2_sign_q);

  // Select the packed word and status flags for the result class.
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    case (s2_cls_q)
      CLS_NAN: begin
        res_d = {1'b0, EXP_ONES, FRAC_QNAN};
        err_d = 1'b1;
      end
      CLS_INF:  res_d = {s2_sign_q, EXP_ONES, {FRAC_W{1'b0}}};
      CLS_ZERO: res_d = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (!s2_exp_q[XW-1] && (s2_exp_q >= EMAX)) begin
          ovf_d = 1'b1;
          inx_d = 1'b1;
          res_d = to_inf ? {s2_sign_q, EXP_ONES, {FRAC_W{1'b0}}}
                         : {s2_sign_q, EXP_MAXF, {FRAC_W{1'b1}}};
        end else if (s2_exp_q[XW-1] || (s2_exp_q == '0)) begin
          // Both operands were normal, so the true product is never zero here.
          unf_d = 1'b1;
          inx_d = 1'b1;
          res_d = {s2_sign_q, {(W-1){1'b0}}};
        end else begin
          inx_d = s2_inx_q;
          res_d = {s2_sign_q, s2_exp_q[EXP_W-1:0], s2_frac_q};
        end
      end
    endcase
  end

  logic         v3_q;
  logic [W-1:0] res_q;
  logic         err_q, ovf_q, unf_q, inx_q;

  // Stage 3 register: the architectural output, held while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      v3_q  <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (adv) begin
      v3_q  <= v2_q;
      res_q <= res_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inx_q <= inx_d;
    end
  end

  assign out_valid = v3_q;
  assign result    = res_q;
  assign error     = err_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

`ifdef FP_MUL_STAT_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

  // Count delivered results carrying error/overflow, saturating at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (v3_q && out_ready) begin
      if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      if (ovf_q && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
  assign ovf_count = ovf_cnt_q;
`else
  assign err_count = 16'd0;
  assign ovf_count = 16'd0;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - randomized self-checking bench for fp_mul_pipe against a numeric reference model
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [1:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        error, overflow, underflow, inexact;
  logic [15:0] err_count, ovf_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [35:0] exp_q[$];
  int          rdy_mode = 0;
  logic        rdy_force = 1'b1;
  logic [15:0] exp_err = 0, exp_ovf = 0;
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out;

  fp_mul_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .round_mode(round_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .error(error), .overflow(overflow), .underflow(underflow), .inexact(inexact),
    .err_count(err_count), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: exact integer product, explicit rounding by remainder vs half.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] rm);
    logic s, zx, zy, ix, iy, nx, ny, inx, up, to_inf;
    int ex, ey, e, sh;
    longint one, fx, fy, p, q, rem, half;
    logic [31:0] r;
    one = 1;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = longint'(x[22:0]);
    fy = longint'(y[22:0]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (fx == 0);
    iy = (ey == 255) && (fy == 0);
    nx = (ex == 255) && (fx != 0);
    ny = (ey == 255) && (fy != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return {4'b1000, 32'h7FC0_0000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    p  = ((one << 23) + fx) * ((one << 23) + fy);
    e  = ex + ey - 127;
    sh = 23;
    if (p >= (one << 47)) begin
      e  = e + 1;
      sh = 24;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = one << (sh - 1);
    inx  = (rem != 0);
    case (rm)
      2'b00:   up = inx && !s;
      2'b01:   up = inx && s;
      2'b10:   up = (rem > half) || ((rem == half) && q[0]);
      default: up = 1'b0;
    endcase
    q = q + longint'(up);
    if (q == (one << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      to_inf = (rm == 2'b10) || ((rm == 2'b00) && !s) || ((rm == 2'b01) && s);
      r = to_inf ? {s, 8'hFF, 23'h0} : {s, 8'hFE, 23'h7FFFFF};
      return {4'b0101, r};
    end
    if (e <= 0) return {4'b0011, s, 31'h0};
    r = {s, e[7:0], q[22:0]};
    return {3'b000, inx, r};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    k = $urandom_range(0, 11);
    case (k)
      0:       return {s, 8'h00, f};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, f | 23'h1};
      3:       return $urandom;
      4:       e = 8'($urandom_range(190, 254));
      5:       e = 8'($urandom_range(1, 64));
      6:       begin e = 8'($urandom_range(120, 134)); f = 23'($urandom_range(0, 3)); end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // Output ready driver: 0 always ready, 1 random, 2 forced by the main sequence.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = rdy_force;
      endcase
    end
  end

  // Scoreboard: pop on handshake, check values, check hold while stalled.
  initial begin
    logic [35:0] want;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_stall = 1'b0;
        exp_err = 0;
        exp_ovf = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", 64'({error, overflow, underflow, inexact, result}), 64'(prev_out));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", 64'(out_valid), 64'd0);
          end else begin
            want = exp_q.pop_front();
            chk("result", 64'(result), 64'(want[31:0]));
            chk("flags", 64'({error, overflow, underflow, inexact}), 64'(want[35:32]));
            if (want[35] && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
            if (want[34] && exp_ovf != 16'hFFFF) exp_ovf = exp_ovf + 16'd1;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {error, overflow, underflow, inexact, result};
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [1:0] xrm,
                      input logic use_c, input logic [35:0] cexp);
    logic done;
    done = 1'b0;
    a = xa; b = xb; round_mode = xrm; in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(use_c ? cexp : model(xa, xb, xrm));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic measure(input logic [31:0] xa, input logic [31:0] xb, input logic [1:0] xrm,
                         input logic [35:0] want);
    int lat;
    a = xa; b = xb; round_mode = xrm; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd3);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] va[8], vb[8];
    logic [1:0]  vr[8];
    int          sent, quiet;
    logic [15:0] nan3;

    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; round_mode = 2'b10;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({error, overflow, underflow, inexact}), 64'd0);
    chk("rst_counters", 64'({err_count, ovf_count}), 64'd0);
    @(posedge clk);
    #1;

    measure(32'h4000_0000, 32'h4040_0000, 2'b10, {4'b0000, 32'h40C0_0000});
    send(32'h3F80_0001, 32'h3F80_0001, 2'b10, 1'b1, {4'b0001, 32'h3F80_0002});
    send(32'h3F80_0001, 32'h3F80_0001, 2'b11, 1'b1, {4'b0001, 32'h3F80_0002});
    send(32'h3F80_0001, 32'h3F80_0001, 2'b00, 1'b1, {4'b0001, 32'h3F80_0003});
    send(32'h3F80_0001, 32'h3F80_0001, 2'b01, 1'b1, {4'b0001, 32'h3F80_0002});
    send(32'h7F00_0000, 32'h4000_0000, 2'b10, 1'b1, {4'b0101, 32'h7F80_0000});
    send(32'h7F00_0000, 32'h4000_0000, 2'b11, 1'b1, {4'b0101, 32'h7F7F_FFFF});
    send(32'h0080_0000, 32'h3F00_0000, 2'b10, 1'b1, {4'b0011, 32'h0000_0000});
    send(32'h7F80_0000, 32'h0000_0000, 2'b10, 1'b1, {4'b1000, 32'h7FC0_0000});
    send(32'hFF80_0000, 32'h4000_0000, 2'b10, 1'b1, {4'b0000, 32'hFF80_0000});
    drain();

    // Eight back-to-back inputs with the consumer stalled in cycles 4..8.
    for (int i = 0; i < 8; i++) begin
      va[i] = rand_op(); vb[i] = rand_op(); vr[i] = 2'($urandom_range(0, 3));
    end
    rdy_force = 1'b1;
    rdy_mode  = 2;
    sent = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      rdy_force = !(cyc >= 4 && cyc <= 8);
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; round_mode = vr[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (cyc == 4) begin
        chk("b2b_out_valid_c4", 64'(out_valid), 64'd1);
        chk("b2b_in_ready_low", 64'(in_ready), 64'd0);
        chk("b2b_accepted_c4", 64'(sent), 64'd3);
      end
      if (cyc == 9) chk("b2b_in_ready_back", 64'(in_ready), 64'd1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, round_mode));
        sent++;
      end
      @(posedge clk);
      #1;
      if (sent == 8 && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    chk("b2b_sent", 64'(sent), 64'd8);
    drain();
    rdy_mode = 0;

    // Reset with two transactions in flight.
    send(rand_op(), rand_op(), 2'b10, 1'b0, '0);
    send(rand_op(), rand_op(), 2'b10, 1'b0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    quiet = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) quiet++;
      @(posedge clk);
      #1;
    end
    chk("flush_quiet", 64'(quiet), 64'd0);
    measure(32'h3FC0_0000, 32'h4000_0000, 2'b10, model(32'h3FC0_0000, 32'h4000_0000, 2'b10));
    for (int i = 0; i < 3; i++) send(32'h7FC0_0000 | 32'($urandom_range(0, 255)), rand_op(), 2'b10, 1'b0, '0);
    drain();
`ifdef FP_MUL_STAT_CNT_EN
    nan3 = 16'd3;
`else
    nan3 = 16'd0;
`endif
    chk("err_count_nan3", 64'(err_count), 64'(nan3));

    // Random operands and modes with a randomly stalling consumer.
    rdy_mode = 1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rand_op(), rand_op(), 2'($urandom_range(0, 3)), 1'b0, '0);
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;
`ifdef FP_MUL_STAT_CNT_EN
    chk("err_count_final", 64'(err_count), 64'(exp_err));
    chk("ovf_count_final", 64'(ovf_count), 64'(exp_ovf));
`else
    chk("err_count_final", 64'(err_count), 64'd0);
    chk("ovf_count_final", 64'(ovf_count), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=4).
REQ-002 SHALL have parameter FRAC_W, default 23, stored fraction width (>=4); word width W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts this cycle.
REQ-007 SHALL have ports a, b  input  W  IEEE-754-style operands.
REQ-008 SHALL have port round_mode  input  2  00 toward +inf, 01 toward -inf, 10 nearest-even, 11 toward zero; sampled with operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  W  product.
REQ-012 SHALL have ports error, overflow, underflow, inexact  output  1 each  status flags aligned with result.
REQ-013 SHALL have ports err_count, ovf_count  output  16 each  event counters (see Configuration).

Function
REQ-014 SHALL be a 3-stage pipeline: S1 decode + mantissa multiply, S2 normalise + round, S3 pack + flags; latency 3 cycles from accept to out_valid.
REQ-015 SHALL accept a transaction when in_valid && in_ready; in_ready = !out_valid || out_ready (global advance, no bubble collapsing).
REQ-016 SHALL hold result and all flags stable while out_valid && !out_ready; no transaction lost, duplicated or reordered.
REQ-017 SHALL sustain one result per cycle with out_ready held high.
REQ-018 SHALL compute sign = sign(a) XOR sign(b) for all non-NaN results.
REQ-019 SHALL treat exponent-zero inputs as signed zero (flush-to-zero inputs).
REQ-020 SHALL compute product exponent at EXP_W+2 signed width: Ea+Eb-bias (bias = 2^(EXP_W-1)-1), +1 when product mantissa in [2,4).
REQ-021 SHALL round from the full 2*(FRAC_W+1)-bit product using guard, round and sticky bits per round_mode; mantissa carry-out after rounding increments exponent.
REQ-022 SHALL set inexact when any discarded bit is nonzero.
REQ-023 SHALL on exponent >= all-ones: overflow=1; result = signed infinity for nearest-even and for directed modes rounding away in the sign direction, else signed max finite.
REQ-024 SHALL on biased exponent <= 0: result = signed zero, underflow=1, inexact=1 unless product exactly zero.
REQ-025 SHALL on any NaN operand, or infinity times zero: result = canonical quiet NaN (sign 0, exponent all-ones, fraction MSB only), error=1.
REQ-026 SHALL on infinity times finite nonzero or infinity: signed infinity, all flags 0.
REQ-027 SHALL treat zero times finite as signed zero, flags 0.

Reset
REQ-028 SHALL on reset clear all stage valids; out_valid=0, result=0, all flags=0, counters=0, in_ready=1 the cycle after release.
REQ-029 SHALL on reset mid-operation discard all in-flight transactions; no result from them appears after reset.

Configuration
REQ-030 SHALL compile event counters only when FP_MUL_STAT_CNT_EN is defined: err_count/ovf_count increment on each handshaken (out_valid && out_ready) result with error/overflow set, saturate at 16'hFFFF.
REQ-031 SHALL without FP_MUL_STAT_CNT_EN tie err_count and ovf_count to 0 and instantiate no counter state.

Verification
REQ-032 SHALL verify 0x40000000 * 0x40400000, mode 10 -> 0x40C00000 exactly 3 cycles after accept, flags 0.
REQ-033 SHALL verify 0x3F800001 * 0x3F800001 -> mode 10 0x3F800002, mode 11 0x3F800002, mode 00 0x3F800003, mode 01 0x3F800002, inexact=1 in all.
REQ-034 SHALL verify 0x7F000000 * 0x40000000 -> mode 10 0x7F800000, mode 11 0x7F7FFFFF, overflow=1 both; 0x00800000 * 0x3F000000 -> 0x00000000, underflow=1.
REQ-035 SHALL verify 0x7F800000 * 0x00000000 -> 0x7FC00000 error=1; 0xFF800000 * 0x40000000 -> 0xFF800000 flags 0.
REQ-036 SHALL verify back-to-back 8 inputs with out_ready low cycles 4-8: in_ready drops once out_valid && !out_ready, all 8 results delivered in order, values stable while stalled.
REQ-037 SHALL verify reset asserted with 2 transactions in flight -> out_valid stays 0 until a new accept plus 3 cycles; with FP_MUL_STAT_CNT_EN, 3 NaN results -> err_count=3.
